// File: rtl/snn_train_sequencer.sv
// snn_train_sequencer: paces presentation windows on the AER neuron tick,
// emits one-tick pixel spikes, drives teacher spikes during a bounded
// training run and classifies each window by per-class spike counts.
// Optional feature macro: SNN_SEQ_NOISE_EN (LFSR-driven single-pixel noise).
module snn_train_sequencer #(
    parameter int NUM_PIXEL     = 49,
    parameter int NUM_CLASS     = 10,
    parameter int CLASS_W       = 4,
    parameter int REST_TIME     = 149,
    parameter int TRAIN_SPIKE   = 10,
    parameter int UNTRAIN_SPIKE = 5,
    parameter int TRAIN_WINDOWS = 412,
    parameter int CNT_W         = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN_NEURON,
    input  logic                 TRAIN_START,
    input  logic                 NOISE_SEL,
    input  logic [NUM_PIXEL-1:0] PIXELS,
    input  logic [CLASS_W-1:0]   LABEL,
    input  logic [NUM_CLASS-1:0] OUT_SPIKES,
    output logic [NUM_PIXEL-1:0] PIXEL_SPIKES,
    output logic [NUM_CLASS-1:0] TEACH_SPIKES,
    output logic                 EN_ADDR,
    output logic                 EN_TRAIN,
    output logic                 TRAINING,
    output logic                 WINDOW_DONE,
    output logic [CLASS_W-1:0]   CLASS_OUT,
    output logic                 CLASS_VALID,
    output logic                 TIE,
    output logic                 NO_SPIKE
);

    localparam int TW = $clog2(REST_TIME + 1);
    localparam int WW = $clog2(TRAIN_WINDOWS + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRAIN = 1'b1;

    logic [TW-1:0]        cnt_q, cnt_d;
    logic [WW-1:0]        wc_q, wc_d;
    logic [0:0]           state_q, state_d;
    logic                 wrap;
    logic [NUM_PIXEL-1:0] pattern;
    logic [NUM_CLASS-1:0] teach_d;
    logic                 label_valid;
    logic [CNT_W-1:0]     spk_cnt_q [NUM_CLASS];
    logic [CNT_W-1:0]     spk_cnt_d [NUM_CLASS];
    logic [CLASS_W-1:0]   class_d;
    logic                 tie_d;
    logic                 no_spike_d;

    assign wrap        = EN_NEURON && (cnt_q == TW'(REST_TIME));
    assign label_valid = ({1'b0, LABEL} < (CLASS_W + 1)'(NUM_CLASS));
    assign TRAINING    = (state_q == ST_TRAIN);
    assign EN_TRAIN    = TRAINING && EN_NEURON;

`ifdef SNN_SEQ_NOISE_EN
    logic [15:0] lfsr_q;

    // Noise LFSR steps once per window; taps 16,14,13,11.
    always_ff @(posedge CLK) begin
        if (RST)
            lfsr_q <= 16'hACE1;
        else if (wrap)
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Invert the one pixel addressed by the LFSR; out-of-range values flip nothing.
    always_comb begin
        pattern = PIXELS;
        for (int i = 0; i < NUM_PIXEL; i++)
            if (NOISE_SEL && (lfsr_q == 16'(i)))
                pattern[i] = ~PIXELS[i];
    end
`else
    logic unused_noise_sel;
    assign unused_noise_sel = NOISE_SEL;
    assign pattern          = PIXELS;
`endif

    // Window counter and run state next-state logic.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cnt_d   = cnt_q;
        wc_d    = wc_q;
        state_d = state_q;
        if (EN_NEURON)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (TRAIN_START) begin
                    state_d = ST_TRAIN;
                    wc_d    = '0;
                end
            end
            default: begin
                if (wrap) begin
                    if (wc_q == WW'(TRAIN_WINDOWS - 1))
                        state_d = ST_IDLE;
                    else
                        wc_d = wc_q + 1'b1;
                end
            end
        endcase
    end

    // Teacher timing: label class early, all others just before the window end.
    always_comb begin
        teach_d = '0;
        if ((state_q == ST_TRAIN) && EN_NEURON) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                if (label_valid && (CLASS_W'(k) == LABEL))
                    teach_d[k] = (cnt_q == TW'(TRAIN_SPIKE));
                else
                    teach_d[k] = (cnt_q == TW'(REST_TIME - UNTRAIN_SPIKE));
            end
        end
    end

    // Argmax over the counts held before this clock; lowest index wins ties.
    always_comb begin
        logic [CNT_W-1:0] best_cnt;
        best_cnt = spk_cnt_q[0];
        class_d  = '0;
        tie_d    = 1'b0;
        for (int k = 1; k < NUM_CLASS; k++) begin
            if (spk_cnt_q[k] > best_cnt) begin
                best_cnt = spk_cnt_q[k];
                class_d  = CLASS_W'(k);
                tie_d    = 1'b0;
            end else if ((spk_cnt_q[k] == best_cnt) && (best_cnt != '0)) begin
                tie_d = 1'b1;
            end
        end
        no_spike_d = (best_cnt == '0);
    end

    // Per-class spike counters: saturate inside a window, reload on the wrap tick.
    always_comb begin
        for (int k = 0; k < NUM_CLASS; k++) begin
            spk_cnt_d[k] = spk_cnt_q[k];
            if (wrap)
                spk_cnt_d[k] = CNT_W'(OUT_SPIKES[k]);
            else if (OUT_SPIKES[k] && (spk_cnt_q[k] != {CNT_W{1'b1}}))
                spk_cnt_d[k] = spk_cnt_q[k] + 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            cnt_q        <= '0;
            wc_q         <= '0;
            state_q      <= ST_IDLE;
            PIXEL_SPIKES <= '0;
            TEACH_SPIKES <= '0;
            EN_ADDR      <= 1'b0;
            WINDOW_DONE  <= 1'b0;
            CLASS_VALID  <= 1'b0;
            CLASS_OUT    <= '0;
            TIE          <= 1'b0;
            NO_SPIKE     <= 1'b0;
            // NOTE: the counter array is small flop storage, so clearing it in reset is intended.
            for (int k = 0; k < NUM_CLASS; k++)
                spk_cnt_q[k] <= '0;
        end else begin
            cnt_q        <= cnt_d;
            wc_q         <= wc_d;
            state_q      <= state_d;
            PIXEL_SPIKES <= wrap ? pattern : '0;
            TEACH_SPIKES <= teach_d;
            EN_ADDR      <= EN_NEURON && (cnt_q == TW'(REST_TIME - 1));
            WINDOW_DONE  <= wrap;
            CLASS_VALID  <= wrap;
            if (wrap) begin
                CLASS_OUT <= class_d;
                TIE       <= tie_d;
                NO_SPIKE  <= no_spike_d;
            end
            for (int k = 0; k < NUM_CLASS; k++)
                spk_cnt_q[k] <= spk_cnt_d[k];
        end
    end

endmodule

// File: doc/snn_train_sequencer.md
# snn_train_sequencer

Parametrised stimulus, teacher and readout sequencer for the Izhikevich spiking network. It paces presentation windows on the AER neuron-enable tick and turns a static pixel pattern into one-tick input spikes. During a bounded training run it drives teacher spikes for a labelled class, and it classifies each window by counting output-neuron spikes. It sits between the board-level image/label inputs and the AER bus, STDP and output-neuron array, and supports any pixel count and class count.

## Interface
- NUM_PIXEL, 49, input pixel neurons
- NUM_CLASS, 10, output/teacher neurons
- CLASS_W, 4, label and class-index width; must satisfy 2^CLASS_W >= NUM_CLASS
- REST_TIME, 149, last window-counter value; window = REST_TIME+1 ticks; >= 4
- TRAIN_SPIKE, 10, counter value for the labelled-class teacher spike
- UNTRAIN_SPIKE, 5, offset before REST_TIME for non-label teacher spikes; TRAIN_SPIKE < REST_TIME-UNTRAIN_SPIKE
- TRAIN_WINDOWS, 412, windows per training run
- CNT_W, 6, per-class spike counter width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- EN_NEURON  in  1  neuron tick from AER bus
- TRAIN_START  in  1  level/pulse; starts a training run
- NOISE_SEL  in  1  request pixel noise
- PIXELS  in  NUM_PIXEL  static pattern
- LABEL  in  CLASS_W  class index of current pattern
- OUT_SPIKES  in  NUM_CLASS  output-neuron spikes
- PIXEL_SPIKES  out  NUM_PIXEL  input spikes, registered
- TEACH_SPIKES  out  NUM_CLASS  teacher spikes, registered
- EN_ADDR  out  1  STDP address-update strobe, registered
- EN_TRAIN  out  1  TRAINING && EN_NEURON, combinational
- TRAINING  out  1  training run active
- WINDOW_DONE  out  1  one-cycle pulse after each window end
- CLASS_OUT  out  CLASS_W  winning class
- CLASS_VALID  out  1  one-cycle pulse, CLASS_OUT updated
- TIE  out  1  winner shared max count
- NO_SPIKE  out  1  all counts zero

## Operation
- Window counter CNT, 0..REST_TIME, advances only on clocks with EN_NEURON=1. It wraps to 0 on the tick where CNT==REST_TIME. That clock is the "wrap tick".
- PIXEL_SPIKES: on the wrap tick, the register loads the pattern (PIXELS, after optional noise). On every other clock it loads 0. Result is a one-clock pulse per window.
- EN_ADDR: one-clock pulse after the tick where CNT==REST_TIME-1.
- States IDLE and TRAIN. IDLE→TRAIN when TRAIN_START=1, which clears the window count WC. TRAIN_START is ignored while in TRAIN, so no restart. TRAIN→IDLE on the wrap tick where WC==TRAIN_WINDOWS-1. TRAINING=1 in TRAIN.
- Teacher spikes, TRAIN only, on ticks:
  - Class LABEL fires when CNT==TRAIN_SPIKE.
  - Every other class fires when CNT==REST_TIME-UNTRAIN_SPIKE.
  - LABEL >= NUM_CLASS: all classes use the non-label timing.
  - Outputs are one-clock pulses; zero otherwise and in IDLE.
- Readout runs in both states:
  - Per-class counter increments on any clock with OUT_SPIKES[k]=1 and saturates at 2^CNT_W-1.
  - On the wrap tick, argmax over the registered counts (before that clock's increment) is latched into CLASS_OUT/TIE/NO_SPIKE. On ties the lowest index wins and TIE=1. All zero gives CLASS_OUT=0 and NO_SPIKE=1.
  - Also on the wrap tick, counters reload to OUT_SPIKES of that clock (0 or 1), so spikes coinciding with the wrap are counted in the new window.
- Reset values: CNT=0, WC=0, state IDLE, all counters 0. Every registered output is 0, and EN_TRAIN=0. RST mid-run aborts training in one clock.

## Timing
- Registered outputs are valid the clock after the causing tick.
- CLASS_VALID and WINDOW_DONE assert together, one clock after the wrap tick.
- TRAINING rises one clock after TRAIN_START is sampled and falls one clock after the final wrap tick. That final window's teacher spikes are all emitted.
- No output depends on clocks without EN_NEURON, except counter sampling of OUT_SPIKES.

## Configuration
- SNN_SEQ_NOISE_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances once per wrap tick.
  - With NOISE_SEL=1, the pixel whose index equals the current LFSR value is inverted in PIXEL_SPIKES. No pixel is flipped if the value >= NUM_PIXEL.
- Undefined: no LFSR. NOISE_SEL is ignored, but the port remains.

## Test plan
- REST_TIME=9 with EN_NEURON constantly 1, PIXELS=49'h1 → PIXEL_SPIKES=49'h1 for exactly one clock every 10 clocks. EN_ADDR pulses one clock earlier each window.
- TRAIN_WINDOWS=3, LABEL=2, pulse TRAIN_START → TEACH_SPIKES[2] fires after CNT=10, and others after CNT=REST_TIME-5, in each of 3 windows. TRAINING then drops and teacher output is 0.
- OUT_SPIKES[3] pulsed 5 times and OUT_SPIKES[7] pulsed 2 times in a window → CLASS_OUT=3, TIE=0, NO_SPIKE=0, with CLASS_VALID for one clock.
- OUT_SPIKES[1] and [4] each pulsed 3 times → CLASS_OUT=1, TIE=1. Empty window → CLASS_OUT=0, NO_SPIKE=1. CNT_W=3 with 12 pulses → counter saturates at 7.
- Assert RST mid-training → next clock TRAINING=0, all outputs 0. A second TRAIN_START during TRAIN does not extend the run.
- With SNN_SEQ_NOISE_EN defined and NOISE_SEL=1 → exactly ≤1 pixel differs from PIXELS per window, matching the LFSR reference model.
